stb_inst_arb: RTL and testbench
===============================

Name: stb_inst_arb

Overview:
- Round-robin arbiter and sequencer that shares one store-to-global-memory engine (micro-instruction port of stb_top) between NUM_REQ requesters.
- Captures a granted requester's store micro-instruction and drives it to the engine as a single-cycle valid pulse.
- Holds exactly one instruction outstanding until the engine reports done, then routes the completion back to the owning requester.
- Includes a watchdog that flags a hung store.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, global base address width.
- UR_ADDR_WIDTH, 11, user register address width.
- TMO_WIDTH, 16, watchdog counter width; timeout fires at 2^TMO_WIDTH-1 cycles.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- i_req_valid  in  NUM_REQ  per-requester instruction valid.
- o_req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- i_req_smc_strb  in  NUM_REQ*6  packed; slice k = [6k+5:6k].
- i_req_byte_strb  in  NUM_REQ*4  packed.
- i_req_brst  in  NUM_REQ*2  packed; 00=1, 01=2, 10=4, 11=8 beats.
- i_req_gr_base_addr  in  NUM_REQ*ADDR_WIDTH  packed.
- i_req_ur_id  in  NUM_REQ*4  packed.
- i_req_ur_addr  in  NUM_REQ*UR_ADDR_WIDTH  packed.
- o_req_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- o_stb_valid  out  1  to engine i_micro_inst_u_valid.
- o_stb_smc_strb  out  6  registered instruction field to engine.
- o_stb_byte_strb  out  4  registered instruction field to engine.
- o_stb_brst  out  2  registered instruction field to engine.
- o_stb_gr_base_addr  out  ADDR_WIDTH  registered instruction field to engine.
- o_stb_ur_id  out  4  registered instruction field to engine.
- o_stb_ur_addr  out  UR_ADDR_WIDTH  registered instruction field to engine.
- i_stb_d_valid  in  1  engine accepted instruction (o_micro_inst_d_valid).
- i_stb_d_done  in  1  engine finished store (o_micro_inst_d_done).
- o_busy  out  1  instruction outstanding.
- o_owner  out  3  index of current or last grantee.
- o_tmo_err  out  1  sticky watchdog error.
- o_state  out  2  FSM state encoding.

Behaviour:

Reset:
- Synchronous reset, active-high, applied on the clk edge.
- All outputs are 0 after reset; FSM enters IDLE.
- The round-robin pointer resets to 0, so requester 0 has highest priority first.
- Reset mid-transaction abandons the outstanding instruction. No o_req_done is issued for it, and any later i_stb_d_done is ignored while in IDLE.

FSM encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.

IDLE:
- If any i_req_valid is high, grant k = the first set bit at or after rr_ptr, with modulo NUM_REQ wrap.
- Assert o_req_ready[k] combinationally in the same cycle; the handshake is i_req_valid[k] & o_req_ready[k].
- On the next edge, latch requester k's fields into the o_stb_* registers and set o_owner=k.
- Then set rr_ptr=(k+1) mod NUM_REQ and go to ISSUE.
- o_req_ready is 0 in every state other than IDLE.

ISSUE:
- o_stb_valid=1 for exactly one cycle, then go to WAIT.
- Latency from requester handshake to o_stb_valid is 1 cycle.

WAIT:
- i_stb_d_valid is informational only and needs no action.
- i_stb_d_done=1 moves the FSM to RESP.
- d_valid and d_done may arrive in the same cycle, or d_done may come first; both cases are legal.

RESP:
- o_req_done[o_owner]=1 for one cycle, then go to IDLE.
- A new grant can occur in the cycle after RESP, so the minimum issue-to-issue spacing is 4 cycles when done returns immediately.

o_busy:
- o_busy = (state != IDLE).

Watchdog:
- The counter clears on entry to ISSUE and increments each cycle in WAIT.
- On reaching all-ones: set o_tmo_err (sticky until rst), force RESP, and still pulse o_req_done so the requester is released.
- The counter saturates and does not wrap.

Stray completions:
- i_stb_d_done in IDLE, ISSUE or RESP is ignored.

Field hold:
- o_stb_* fields hold their value after issue until the next grant.

Test Plan:
- Single requester: req1 valid with gr_base_addr=0x0000_1000 and brst=2'b10. Expect o_req_ready[1] in the same cycle and o_stb_valid 1 cycle later with addr 0x1000. d_done asserted 5 cycles later -> o_req_done[1] pulses in the cycle after d_done, and o_busy falls.
- Round robin: all 4 requesters valid continuously, d_done returned 1 cycle after issue -> grant order 0,1,2,3,0 and issue spacing of exactly 4 cycles.
- Wrap and skip: rr_ptr=3, only req1 and req2 valid -> req1 granted, then rr_ptr=2 -> req2 granted next.
- Simultaneous and early done: d_valid and d_done asserted in the same cycle as the first WAIT cycle -> RESP in the next cycle and no extra o_stb_valid pulse. A stray d_done in IDLE -> no o_req_done.
- Watchdog with TMO_WIDTH=4: no d_done -> after 15 WAIT cycles o_tmo_err=1 and o_req_done[owner] pulses. o_tmo_err stays high through later normal transactions until rst.
- Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0 and state IDLE. A late d_done is ignored, and the next grant goes to requester 0.

Source files
------------

// File: rtl/stb_inst_arb_if.sv
// Request and engine-side bus of the store-instruction arbiter.
// slave = arbiter view, master = requesters plus engine view.
interface stb_inst_arb_if #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned UR_ADDR_WIDTH = 11
);
  logic [NUM_REQ-1:0]               i_req_valid;
  logic [NUM_REQ-1:0]               o_req_ready;
  logic [NUM_REQ*6-1:0]             i_req_smc_strb;
  logic [NUM_REQ*4-1:0]             i_req_byte_strb;
  logic [NUM_REQ*2-1:0]             i_req_brst;
  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_gr_base_addr;
  logic [NUM_REQ*4-1:0]             i_req_ur_id;
  logic [NUM_REQ*UR_ADDR_WIDTH-1:0] i_req_ur_addr;
  logic [NUM_REQ-1:0]               o_req_done;

  logic                     o_stb_valid;
  logic [5:0]               o_stb_smc_strb;
  logic [3:0]               o_stb_byte_strb;
  logic [1:0]               o_stb_brst;
  logic [ADDR_WIDTH-1:0]    o_stb_gr_base_addr;
  logic [3:0]               o_stb_ur_id;
  logic [UR_ADDR_WIDTH-1:0] o_stb_ur_addr;
  logic                     i_stb_d_valid;
  logic                     i_stb_d_done;

  modport slave (
    input  i_req_valid, i_req_smc_strb, i_req_byte_strb, i_req_brst,
           i_req_gr_base_addr, i_req_ur_id, i_req_ur_addr,
           i_stb_d_valid, i_stb_d_done,
    output o_req_ready, o_req_done,
           o_stb_valid, o_stb_smc_strb, o_stb_byte_strb, o_stb_brst,
           o_stb_gr_base_addr, o_stb_ur_id, o_stb_ur_addr
  );

  modport master (
    output i_req_valid, i_req_smc_strb, i_req_byte_strb, i_req_brst,
           i_req_gr_base_addr, i_req_ur_id, i_req_ur_addr,
           i_stb_d_valid, i_stb_d_done,
    input  o_req_ready, o_req_done,
           o_stb_valid, o_stb_smc_strb, o_stb_byte_strb, o_stb_brst,
           o_stb_gr_base_addr, o_stb_ur_id, o_stb_ur_addr
  );
endinterface

// File: rtl/stb_inst_arb.sv
// Round-robin arbiter sharing one store engine between NUM_REQ requesters:
// one instruction outstanding at a time, completion routed to its owner.
module stb_inst_arb #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned UR_ADDR_WIDTH = 11,
  parameter int unsigned TMO_WIDTH     = 16
) (
  input  logic          clk,
  input  logic          rst,
  stb_inst_arb_if.slave bus,
  output logic          o_busy,
  output logic [2:0]    o_owner,
  output logic          o_tmo_err,
  output logic [1:0]    o_state
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]               owner_q, owner_d;
  logic [5:0]               smc_strb_q, smc_strb_d;
  logic [3:0]               byte_strb_q, byte_strb_d;
  logic [1:0]               brst_q, brst_d;
  logic [ADDR_WIDTH-1:0]    gr_base_addr_q, gr_base_addr_d;
  logic [3:0]               ur_id_q, ur_id_d;
  logic [UR_ADDR_WIDTH-1:0] ur_addr_q, ur_addr_d;
  logic                     stb_valid_q, stb_valid_d;
  logic [NUM_REQ-1:0]       req_done_q, req_done_d;
  logic [TMO_WIDTH-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                     tmo_err_q, tmo_err_d;
  logic                     busy_q, busy_d;

  logic                     grant_vld_c;
  logic [PTR_W-1:0]         grant_idx_c;
  logic [NUM_REQ-1:0]       req_ready_c;
  logic [TMO_WIDTH-1:0]     tmo_inc_c;
  logic                     unused_d_valid;

  // The engine's accept strobe carries no information the sequencer needs.
  assign unused_d_valid = bus.i_stb_d_valid;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : rr_pick
    int unsigned idx;
    idx         = 0;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld_c && bus.i_req_valid[PTR_W'(idx)]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = PTR_W'(idx);
      end
    end
  end

  assign req_ready_c = (state_q == IDLE && grant_vld_c) ? (NUM_REQ'(1) << grant_idx_c) : '0;
  assign tmo_inc_c   = tmo_cnt_q + TMO_WIDTH'(1);

  // Sequencer: grant/capture, one-cycle issue, wait for done or timeout, respond.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    smc_strb_d     = smc_strb_q;
    byte_strb_d    = byte_strb_q;
    brst_d         = brst_q;
    gr_base_addr_d = gr_base_addr_q;
    ur_id_d        = ur_id_q;
    ur_addr_d      = ur_addr_q;
    stb_valid_d    = 1'b0;
    req_done_d     = '0;
    tmo_cnt_d      = tmo_cnt_q;
    tmo_err_d      = tmo_err_q;

    unique case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          state_d        = ISSUE;
          owner_d        = 3'(grant_idx_c);
          smc_strb_d     = bus.i_req_smc_strb[32'(grant_idx_c)*6 +: 6];
          byte_strb_d    = bus.i_req_byte_strb[32'(grant_idx_c)*4 +: 4];
          brst_d         = bus.i_req_brst[32'(grant_idx_c)*2 +: 2];
          gr_base_addr_d = bus.i_req_gr_base_addr[32'(grant_idx_c)*ADDR_WIDTH +: ADDR_WIDTH];
          ur_id_d        = bus.i_req_ur_id[32'(grant_idx_c)*4 +: 4];
          ur_addr_d      = bus.i_req_ur_addr[32'(grant_idx_c)*UR_ADDR_WIDTH +: UR_ADDR_WIDTH];
          rr_ptr_d       = (32'(grant_idx_c) == NUM_REQ - 1) ? '0 : grant_idx_c + PTR_W'(1);
          stb_valid_d    = 1'b1;
          tmo_cnt_d      = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (tmo_cnt_q != '1) tmo_cnt_d = tmo_inc_c;
        if (bus.i_stb_d_done) begin
          state_d    = RESP;
          req_done_d = NUM_REQ'(1) << owner_q;
        end else if (tmo_inc_c == '1) begin
          // Hung store: release the requester anyway and flag it.
          state_d    = RESP;
          tmo_err_d  = 1'b1;
          req_done_d = NUM_REQ'(1) << owner_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      smc_strb_q     <= '0;
      byte_strb_q    <= '0;
      brst_q         <= '0;
      gr_base_addr_q <= '0;
      ur_id_q        <= '0;
      ur_addr_q      <= '0;
      stb_valid_q    <= 1'b0;
      req_done_q     <= '0;
      tmo_cnt_q      <= '0;
      tmo_err_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      smc_strb_q     <= smc_strb_d;
      byte_strb_q    <= byte_strb_d;
      brst_q         <= brst_d;
      gr_base_addr_q <= gr_base_addr_d;
      ur_id_q        <= ur_id_d;
      ur_addr_q      <= ur_addr_d;
      stb_valid_q    <= stb_valid_d;
      req_done_q     <= req_done_d;
      tmo_cnt_q      <= tmo_cnt_d;
      tmo_err_q      <= tmo_err_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.o_req_ready        = req_ready_c;
  assign bus.o_req_done         = req_done_q;
  assign bus.o_stb_valid        = stb_valid_q;
  assign bus.o_stb_smc_strb     = smc_strb_q;
  assign bus.o_stb_byte_strb    = byte_strb_q;
  assign bus.o_stb_brst         = brst_q;
  assign bus.o_stb_gr_base_addr = gr_base_addr_q;
  assign bus.o_stb_ur_id        = ur_id_q;
  assign bus.o_stb_ur_addr      = ur_addr_q;
  assign o_busy                 = busy_q;
  assign o_owner                = owner_q;
  assign o_tmo_err              = tmo_err_q;
  assign o_state                = state_q;
endmodule

// File: tb/tb_stb_inst_arb.sv
// Scoreboard bench for stb_inst_arb: a timeline model predicts grants, issue
// pulses and completions; a negedge monitor compares whatever the DUT presents.
module tb_stb_inst_arb;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned UW = 11;
  localparam int unsigned TW = 4;
  localparam int TMO_LIM = (1 << TW) - 1;

  typedef struct packed {
    logic [5:0]    smc;
    logic [3:0]    bs;
    logic [1:0]    brst;
    logic [AW-1:0] addr;
    logic [3:0]    id;
    logic [UW-1:0] ura;
  } instr_t;
  typedef struct { int cyc; int owner; instr_t ins; } iss_t;
  typedef struct { int cyc; int owner; bit err; instr_t ins; } dn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       o_busy;
  logic [2:0] o_owner;
  logic       o_tmo_err;
  logic [1:0] o_state;

  stb_inst_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .UR_ADDR_WIDTH(UW)) bus ();

  stb_inst_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .UR_ADDR_WIDTH(UW), .TMO_WIDTH(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .o_busy    (o_busy),
    .o_owner   (o_owner),
    .o_tmo_err (o_tmo_err),
    .o_state   (o_state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc, rr, idle_from, done_at, d_mode, chk_idle_at;
  bit err_sticky, stray_en, mon_en;
  logic [NR-1:0] exp_ready;
  instr_t rq[NR][$];
  iss_t   iss_q[$];
  dn_t    dn_q[$];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic instr_t stb_now();
    instr_t r;
    r.smc  = bus.o_stb_smc_strb;
    r.bs   = bus.o_stb_byte_strb;
    r.brst = bus.o_stb_brst;
    r.addr = bus.o_stb_gr_base_addr;
    r.id   = bus.o_stb_ur_id;
    r.ura  = bus.o_stb_ur_addr;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.smc  = 6'($urandom);
    r.bs   = 4'($urandom);
    r.brst = 2'($urandom);
    r.addr = 32'($urandom);
    r.id   = 4'($urandom);
    r.ura  = UW'($urandom);
    return r;
  endfunction

  function automatic bit rq_empty();
    for (int k = 0; k < NR; k++) if (rq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of stimulus; the model decides grants from the round-robin rule
  // and schedules the engine's done plus every expected DUT response.
  task automatic step();
    logic [NR-1:0] v;
    instr_t ins;
    int w, dd, dly;
    bit tmo;
    @(posedge clk); #1; cyc++;
    v = '0;
    for (int k = 0; k < NR; k++) begin
      if (rq[k].size() > 0) begin
        v[k] = 1'b1;
        ins  = rq[k][0];
      end else begin
        ins  = rand_instr();
      end
      bus.i_req_smc_strb[k*6 +: 6]          = ins.smc;
      bus.i_req_byte_strb[k*4 +: 4]         = ins.bs;
      bus.i_req_brst[k*2 +: 2]              = ins.brst;
      bus.i_req_gr_base_addr[k*AW +: AW]    = ins.addr;
      bus.i_req_ur_id[k*4 +: 4]             = ins.id;
      bus.i_req_ur_addr[k*UW +: UW]         = ins.ura;
    end
    bus.i_req_valid   = v;
    bus.i_stb_d_done  = (cyc == done_at) || (stray_en && cyc >= idle_from && $urandom_range(0, 3) == 0);
    bus.i_stb_d_valid = (cyc == done_at) ? 1'b1 : 1'($urandom_range(0, 1));
    exp_ready = '0;
    if (cyc >= idle_from && v != '0) begin
      w = 0;
      for (int i = NR - 1; i >= 0; i--) if (v[(rr + i) % NR]) w = (rr + i) % NR;
      exp_ready = NR'(1) << w;
      dly = (d_mode > 0) ? d_mode : $urandom_range(1, 8);
      tmo = (dly > TMO_LIM);
      dd  = tmo ? TMO_LIM : dly;
      err_sticky = err_sticky | tmo;
      iss_q.push_back('{cyc + 1, w, rq[w][0]});
      dn_q.push_back('{cyc + 2 + dd, w, err_sticky, rq[w][0]});
      done_at   = tmo ? -1 : cyc + 1 + dly;
      idle_from = cyc + 3 + dd;
      rr        = (w + 1) % NR;
      void'(rq[w].pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(rq_empty() && cyc + 1 >= idle_from && iss_q.size() == 0 && dn_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check(1'b0, "drain_timeout", 64'(n), 64'(budget));
    repeat (2) step();
  endtask

  // One reset cycle; expectations later than the reset edge are abandoned.
  task automatic do_reset();
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
    bus.i_req_valid  = '0;
    bus.i_stb_d_done = 1'b0;
    bus.i_stb_d_valid = 1'b0;
    exp_ready = '0;
    for (int i = iss_q.size() - 1; i >= 0; i--) if (iss_q[i].cyc > cyc) iss_q.delete(i);
    for (int i = dn_q.size() - 1; i >= 0; i--) if (dn_q[i].cyc > cyc) dn_q.delete(i);
    done_at = -1; rr = 0; err_sticky = 1'b0; idle_from = cyc + 1;
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check({bus.o_req_ready, bus.o_req_done, bus.o_stb_valid, o_busy, o_owner, o_tmo_err, o_state} == '0,
          "reset_ctrl", 64'({bus.o_req_ready, bus.o_req_done, bus.o_stb_valid, o_busy, o_owner, o_tmo_err, o_state}), 64'(0));
    check(stb_now() == '0, "reset_fields", 64'(stb_now()), 64'(0));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an issue or done.
  always @(negedge clk) begin : mon
    iss_t e;
    dn_t  d;
    if (mon_en) begin
      check(bus.o_req_ready == exp_ready, "req_ready", 64'(bus.o_req_ready), 64'(exp_ready));
      while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
        check(1'b0, "issue_missing", 64'(cyc), 64'(iss_q[0].cyc));
        void'(iss_q.pop_front());
      end
      while (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin
        check(1'b0, "done_missing", 64'(cyc), 64'(dn_q[0].cyc));
        void'(dn_q.pop_front());
      end
      if (bus.o_stb_valid) begin
        if (iss_q.size() == 0) begin
          check(1'b0, "issue_unexpected", 64'(1), 64'(0));
        end else begin
          e = iss_q.pop_front();
          check(e.cyc == cyc, "issue_cycle", 64'(cyc), 64'(e.cyc));
          check(o_owner == 3'(e.owner), "issue_owner", 64'(o_owner), 64'(e.owner));
          check(stb_now() == e.ins, "issue_fields", 64'(stb_now()), 64'(e.ins));
          check(o_busy == 1'b1, "issue_busy", 64'(o_busy), 64'(1));
        end
      end
      if (bus.o_req_done != '0) begin
        if (dn_q.size() == 0) begin
          check(1'b0, "done_unexpected", 64'(bus.o_req_done), 64'(0));
        end else begin
          d = dn_q.pop_front();
          check(d.cyc == cyc, "done_cycle", 64'(cyc), 64'(d.cyc));
          check(bus.o_req_done == NR'(1) << d.owner, "done_owner", 64'(bus.o_req_done), 64'(NR'(1) << d.owner));
          check(o_tmo_err == d.err, "done_tmo_err", 64'(o_tmo_err), 64'(d.err));
          check(stb_now() == d.ins, "fields_held", 64'(stb_now()), 64'(d.ins));
          check(o_busy == 1'b1 && o_owner == 3'(d.owner), "done_busy_owner", 64'({o_busy, o_owner}), 64'({1'b1, 3'(d.owner)}));
          chk_idle_at = cyc + 1;
        end
      end
      if (cyc == chk_idle_at)
        check(o_busy == 1'b0 && o_state == 2'd0, "idle_after_done", 64'({o_busy, o_state}), 64'(0));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    instr_t t;
    rst = 1'b1;
    bus.i_req_valid = '0; bus.i_req_smc_strb = '0; bus.i_req_byte_strb = '0; bus.i_req_brst = '0;
    bus.i_req_gr_base_addr = '0; bus.i_req_ur_id = '0; bus.i_req_ur_addr = '0;
    bus.i_stb_d_valid = 1'b0; bus.i_stb_d_done = 1'b0;
    cyc = 0; rr = 0; idle_from = 0; done_at = -1; d_mode = 0; chk_idle_at = -1;
    err_sticky = 1'b0; stray_en = 1'b0; mon_en = 1'b0; exp_ready = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Single requester, done five cycles after issue.
    t = rand_instr(); t.addr = 32'h0000_1000; t.brst = 2'b10;
    rq[1].push_back(t);
    d_mode = 5;
    drain(60);

    // All four requesters continuously valid, immediate done.
    do_reset();
    for (int r = 0; r < 2; r++) for (int k = 0; k < NR; k++) rq[k].push_back(rand_instr());
    rq[0].push_back(rand_instr());
    d_mode = 1;
    drain(100);

    // Pointer at 3 with only req1 and req2 pending: 1 then 2.
    do_reset();
    d_mode = 2;
    rq[2].push_back(rand_instr());
    step();
    rq[1].push_back(rand_instr());
    rq[2].push_back(rand_instr());
    drain(60);

    // Done together with d_valid in the first wait cycle, strays while idle.
    stray_en = 1'b1;
    d_mode = 1;
    for (int k = 0; k < NR; k++) rq[k].push_back(rand_instr());
    drain(80);
    repeat (12) step();

    // Hung store, then normal traffic with the sticky error still set.
    stray_en = 1'b0;
    d_mode = 100;
    rq[3].push_back(rand_instr());
    drain(60);
    d_mode = 2;
    rq[0].push_back(rand_instr());
    rq[2].push_back(rand_instr());
    drain(60);

    // Reset while waiting, late done ignored, requester 0 wins afterwards.
    d_mode = 10;
    rq[2].push_back(rand_instr());
    repeat (4) step();
    do_reset();
    done_at = cyc + 1;
    repeat (3) step();
    d_mode = 3;
    for (int k = 0; k < NR; k++) rq[k].push_back(rand_instr());
    drain(100);

    // Random traffic with occasional hung stores and stray completions.
    stray_en = 1'b1;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, NR - 1);
        if (rq[k].size() < 3) rq[k].push_back(rand_instr());
      end
      d_mode = ($urandom_range(0, 24) == 0) ? 40 : 0;
      step();
    end
    d_mode = 0;
    drain(3000);

    check(iss_q.size() == 0 && dn_q.size() == 0, "scoreboard_empty",
          64'(iss_q.size() + dn_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
